seq_detect_ctrl: RTL and testbench
==================================

SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 Parameter: MAXLEN, default 8, maximum pattern length in bits.
REQ-002 Parameter: CNT_W, default 8, width of the match counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 cfg_valid  input  1  configuration offer.
REQ-006 cfg_ready  output  1  block can accept configuration this cycle.
REQ-007 cfg_pattern  input  MAXLEN  pattern; bit cfg_len-1 is the earliest-arriving bit.
REQ-008 cfg_len  input  4  pattern length; legal range 1..MAXLEN.
REQ-009 cfg_overlap  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
REQ-010 start  input  1  single-cycle request to begin detection.
REQ-011 stop  input  1  single-cycle request to end detection.
REQ-012 din_valid  input  1  serial bit qualifier.
REQ-013 din  input  1  serial data bit.
REQ-014 match  output  1  registered one-cycle pulse per detected pattern.
REQ-015 match_cnt  output  CNT_W  saturating count of matches since last start.
REQ-016 busy  output  1  high while in RUN.
REQ-017 cfg_err  output  1  one-cycle pulse on rejected configuration.

Function
REQ-018 FSM states: IDLE (unconfigured), ARMED (configured, not running), RUN (detecting).
REQ-019 cfg_ready SHALL be 1 in IDLE and ARMED, 0 in RUN; handshake completes when cfg_valid & cfg_ready.
REQ-020 A completed handshake with cfg_len in 1..MAXLEN SHALL latch pattern/len/overlap and move IDLE->ARMED (ARMED stays ARMED).
REQ-021 A completed handshake with cfg_len 0 or >MAXLEN SHALL pulse cfg_err next cycle, leave stored configuration and state unchanged.
REQ-022 start in ARMED SHALL enter RUN next cycle and clear history, fill count and match_cnt; start in IDLE or RUN SHALL be ignored.
REQ-023 stop in RUN SHALL return to ARMED next cycle; match_cnt holds its value.
REQ-024 start and stop asserted together in ARMED: stop wins, state remains ARMED.
REQ-025 In RUN, each din_valid cycle SHALL shift din into a MAXLEN-bit history (newest at bit 0) and increment a fill count saturating at len; cycles without din_valid SHALL leave history unchanged.
REQ-026 Match condition: fill count = len and history[len-1:0] == pattern[len-1:0], evaluated on the updated history.
REQ-027 match SHALL assert exactly one cycle after the din_valid cycle completing the pattern (latency 1).
REQ-028 On a match with cfg_overlap=0 the fill count SHALL reset to 0; with cfg_overlap=1 it SHALL remain at len.
REQ-029 match_cnt SHALL increment on each match and saturate at 2^CNT_W-1.
REQ-030 din_valid coincident with stop SHALL be processed (may produce match) before leaving RUN.
REQ-031 Configuration inputs SHALL not affect a RUN in progress.

Reset
REQ-032 rst SHALL force IDLE, clear history, fill count, stored configuration, match_cnt; match=0, cfg_err=0, busy=0, cfg_ready=1 on the following cycle.
REQ-033 rst asserted mid-RUN SHALL abandon detection; no match pulse SHALL follow.
REQ-034 rst SHALL take priority over every other input.

Structure
REQ-035 Shared package seq_detect_pkg SHALL hold the state enum (IDLE, ARMED, RUN), MAXLEN and CNT_W defaults.
REQ-036 Sub-module seq_shift_cmp SHALL implement history shift register, fill counter and length-masked compare; the top holds the FSM, config registers and counter.

Verification
REQ-037 cfg 110 len3 overlap=0, start, din 1,1,0,1,1,0 -> match pulses after bits 3 and 6, match_cnt=2.
REQ-038 cfg 11 len2, din 1,1,1: overlap=1 -> 2 matches; overlap=0 -> 1 match.
REQ-039 Valid cfg then cfg_len=0 -> cfg_err one cycle, earlier pattern still detected after start.
REQ-040 Pattern 1 len1, 300 valid 1-bits -> match_cnt saturates at 255.
REQ-041 din 1,1 then din_valid low 5 cycles then 0 (pattern 110) -> single match; rst asserted mid-RUN -> IDLE, all outputs zero, no match.
REQ-042 start+stop same cycle in ARMED -> busy stays 0; start in IDLE -> ignored.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared types and defaults for the serial pattern detector.
package seq_detect_pkg;
   localparam int MAXLEN_DEF = 8;
   localparam int CNT_W_DEF  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2
   } state_t;
endpackage

// File: rtl/seq_shift_cmp.sv
// History shift register, fill counter and length-masked pattern compare.
module seq_shift_cmp
   import seq_detect_pkg::*;
#(
   parameter int MAXLEN = MAXLEN_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              shift,
   input  logic              din,
   input  logic [MAXLEN-1:0] pattern,
   input  logic [3:0]        len,
   input  logic              overlap,
   output logic              hit
);
   logic [MAXLEN-1:0] hist;
   logic [MAXLEN-1:0] hist_n;
   logic [MAXLEN-1:0] mask;
   logic [3:0]        fill;
   logic [3:0]        fill_n;

   // hit is judged on the history as it will look after this shift
   always_comb begin
      hist_n = {hist[MAXLEN-2:0], din};
      fill_n = (fill >= len) ? len : fill + 4'd1;
      for (int i = 0; i < MAXLEN; i++)
         mask[i] = (i < int'(len));
      hit = shift && (fill_n == len) &&
            (((hist_n ^ pattern) & mask) == '0);
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         hist <= '0;
         fill <= '0;
      end else if (shift) begin
         hist <= hist_n;
         fill <= (hit && !overlap) ? 4'd0 : fill_n;
      end
   end
endmodule

// File: rtl/seq_detect_ctrl.sv
// Configurable serial pattern detector: FSM, config registers, match counter.
module seq_detect_ctrl
   import seq_detect_pkg::*;
#(
   parameter int MAXLEN = MAXLEN_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [MAXLEN-1:0] cfg_pattern,
   input  logic [3:0]        cfg_len,
   input  logic              cfg_overlap,
   input  logic              start,
   input  logic              stop,
   input  logic              din_valid,
   input  logic              din,
   output logic              match,
   output logic [CNT_W-1:0]  match_cnt,
   output logic              busy,
   output logic              cfg_err
);
   state_t            state, state_n;
   logic [MAXLEN-1:0] pat_q;
   logic [3:0]        len_q;
   logic              ovl_q;
   logic              cfg_fire;
   logic              len_ok;
   logic              go;
   logic              shift;
   logic              hit;

   assign cfg_ready = (state != RUN);
   assign busy      = (state == RUN);
   assign cfg_fire  = cfg_valid && cfg_ready;
   assign len_ok    = (cfg_len != 4'd0) && (int'(cfg_len) <= MAXLEN);
   assign go        = (state == ARMED) && start && !stop;
   assign shift     = (state == RUN) && din_valid;

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (cfg_fire && len_ok) state_n = ARMED;
         ARMED:   if (go)                 state_n = RUN;
         RUN:     if (stop)               state_n = ARMED;
         default:                         state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pat_q     <= '0;
         len_q     <= '0;
         ovl_q     <= 1'b0;
         match     <= 1'b0;
         match_cnt <= '0;
         cfg_err   <= 1'b0;
      end else begin
         state   <= state_n;
         match   <= hit;
         cfg_err <= cfg_fire && !len_ok;
         if (cfg_fire && len_ok) begin
            pat_q <= cfg_pattern;
            len_q <= cfg_len;
            ovl_q <= cfg_overlap;
         end
         if (go)
            match_cnt <= '0;
         else if (hit && (match_cnt != '1))
            match_cnt <= match_cnt + 1'b1;
      end
   end

   seq_shift_cmp #(.MAXLEN(MAXLEN)) u_shift_cmp (
      .clk     (clk),
      .rst     (rst),
      .clr     (go),
      .shift   (shift),
      .din     (din),
      .pattern (pat_q),
      .len     (len_q),
      .overlap (ovl_q),
      .hit     (hit)
   );
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed self-checking bench for seq_detect_ctrl with a match scoreboard.
module tb_seq_detect_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cfg_valid = 1'b0;
   logic       cfg_ready;
   logic [7:0] cfg_pattern = '0;
   logic [3:0] cfg_len = '0;
   logic       cfg_overlap = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       din_valid = 1'b0;
   logic       din = 1'b0;
   logic       match;
   logic [7:0] match_cnt;
   logic       busy;
   logic       cfg_err;

   int total = 0;
   int bad   = 0;
   logic exp_q[$];

   seq_detect_ctrl #(.MAXLEN(8), .CNT_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .start       (start),
      .stop        (stop),
      .din_valid   (din_valid),
      .din         (din),
      .match       (match),
      .match_cnt   (match_cnt),
      .busy        (busy),
      .cfg_err     (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b, input logic exp, input logic stp);
      logic e;
      din_valid = 1'b1;
      din       = b;
      stop      = stp;
      exp_q.push_back(exp);
      tick();
      din_valid = 1'b0;
      stop      = 1'b0;
      e = exp_q.pop_front();
      chk("match", 32'(match), 32'(e));
   endtask

   task automatic send_cfg(input logic [7:0] p, input logic [3:0] l,
                           input logic ov, input logic exp_err);
      cfg_valid   = 1'b1;
      cfg_pattern = p;
      cfg_len     = l;
      cfg_overlap = ov;
      tick();
      cfg_valid = 1'b0;
      chk("cfg_err", 32'(cfg_err), 32'(exp_err));
   endtask

   task automatic pulse(input logic s, input logic p);
      start = s;
      stop  = p;
      tick();
      start = 1'b0;
      stop  = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_ready", 32'(cfg_ready), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_match", 32'(match), 0);
      chk("rst_err", 32'(cfg_err), 0);
      chk("rst_cnt", 32'(match_cnt), 0);

      pulse(1'b1, 1'b0);
      chk("start_idle_busy", 32'(busy), 0);

      // 110 non-overlap, stream 110110
      send_cfg(8'b110, 4'd3, 1'b0, 1'b0);
      pulse(1'b1, 1'b0);
      chk("run_busy", 32'(busy), 1);
      chk("run_ready", 32'(cfg_ready), 0);
      send_bit(1, 0, 0); send_bit(1, 0, 0); send_bit(0, 1, 0);
      send_bit(1, 0, 0); send_bit(1, 0, 0); send_bit(0, 1, 0);
      chk("cnt_110", 32'(match_cnt), 2);
      pulse(1'b0, 1'b1);
      chk("stop_busy", 32'(busy), 0);
      chk("stop_cnt_hold", 32'(match_cnt), 2);

      // 11 overlapping vs not
      send_cfg(8'b11, 4'd2, 1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      chk("start_clr_cnt", 32'(match_cnt), 0);
      send_bit(1, 0, 0); send_bit(1, 1, 0); send_bit(1, 1, 0);
      chk("cnt_ovl", 32'(match_cnt), 2);
      pulse(1'b0, 1'b1);
      send_cfg(8'b11, 4'd2, 1'b0, 1'b0);
      pulse(1'b1, 1'b0);
      send_bit(1, 0, 0); send_bit(1, 1, 0); send_bit(1, 0, 0);
      chk("cnt_novl", 32'(match_cnt), 1);
      pulse(1'b0, 1'b1);

      // rejected configs keep the earlier pattern
      send_cfg(8'b110, 4'd3, 1'b0, 1'b0);
      send_cfg(8'b1, 4'd0, 1'b1, 1'b1);
      tick();
      chk("err_one_cycle", 32'(cfg_err), 0);
      send_cfg(8'b1, 4'd9, 1'b1, 1'b1);
      pulse(1'b1, 1'b0);
      send_cfg(8'b1, 4'd0, 1'b1, 1'b0);
      send_bit(1, 0, 0); send_bit(1, 0, 0); send_bit(0, 1, 0);

      // idle gap inside pattern, then stop coincident with last bit
      send_bit(1, 0, 0); send_bit(1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("gap_match", 32'(match), 0);
      end
      send_bit(0, 1, 0);
      send_bit(1, 0, 0); send_bit(1, 0, 0); send_bit(0, 1, 1);
      chk("stop_din_busy", 32'(busy), 0);
      chk("stop_din_cnt", 32'(match_cnt), 3);

      pulse(1'b1, 1'b1);
      chk("start_stop_busy", 32'(busy), 0);

      // saturation
      send_cfg(8'b1, 4'd1, 1'b0, 1'b0);
      pulse(1'b1, 1'b0);
      for (int i = 0; i < 300; i++)
         send_bit(1, 1, 0);
      chk("cnt_sat", 32'(match_cnt), 255);
      pulse(1'b0, 1'b1);

      // reset mid-run
      send_cfg(8'b110, 4'd3, 1'b0, 1'b0);
      pulse(1'b1, 1'b0);
      send_bit(1, 0, 0); send_bit(1, 0, 0);
      rst = 1'b1; din_valid = 1'b1; din = 1'b0;
      tick();
      rst = 1'b0; din_valid = 1'b0;
      chk("rst_run_match", 32'(match), 0);
      chk("rst_run_busy", 32'(busy), 0);
      chk("rst_run_cnt", 32'(match_cnt), 0);
      chk("rst_run_ready", 32'(cfg_ready), 1);
      tick();
      chk("rst_run_match2", 32'(match), 0);
      pulse(1'b1, 1'b0);
      chk("rst_start_idle", 32'(busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
